// File: rtl/dffrs_bank_pkg.sv
// rtl/dffrs_bank_pkg.sv - shared constants and per-bit override resolve for dffrs_bank
package dffrs_bank_pkg;

  localparam int OVR_CNT_W = 8;
  localparam logic [OVR_CNT_W-1:0] OVR_CNT_MAX = 8'd255;

  // Reset override wins over set override; both inactive passes the base bit.
  function automatic logic resolve_bit(input logic base, input logic rn, input logic setn);
    logic r;
    r = base;
    if (!setn) r = 1'b1;
    if (!rn) r = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/dffrs_bank_stage.sv
// rtl/dffrs_bank_stage.sv - one WIDTH-bit data + valid pipeline stage with sync reset and load enable
module dffrs_bank_stage #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             load_vld,
  output logic [WIDTH-1:0] word,
  output logic             vld
);

  always_ff @(posedge clk) begin
    if (rst) begin
      word <= RESET_VAL;
      vld  <= 1'b0;
    end else if (load) begin
      word <= load_word;
      vld  <= load_vld;
    end
  end

endmodule

// File: rtl/dffrs_bank.sv
// rtl/dffrs_bank.sv - WIDTH x DEPTH retiming pipeline with per-bit set/reset overrides on stage 0
// Optional saturating override-cycle counter on OVR_CNT when DFFRS_BANK_OVR_CNT_EN is defined.
module dffrs_bank
  import dffrs_bank_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [WIDTH-1:0]     D,
  input  logic                 D_VLD,
  input  logic [WIDTH-1:0]     RN,
  input  logic [WIDTH-1:0]     SETN,
  output logic [WIDTH-1:0]     Q,
  output logic                 Q_VLD
`ifdef DFFRS_BANK_OVR_CNT_EN
  ,
  output logic [OVR_CNT_W-1:0] OVR_CNT
`endif
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_word;
  logic [DEPTH-1:0]            stage_vld;
  logic [WIDTH-1:0]            base;
  logic [WIDTH-1:0]            resolved;
  logic                        vld0_next;

  // While holding, stage 0 re-resolves its own word so overrides act in place.
  always_comb begin
    base      = EN ? D : stage_word[0];
    vld0_next = EN ? D_VLD : stage_vld[0];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_resolve
    assign resolved[i] = resolve_bit(base[i], RN[i], SETN[i]);
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      dffrs_bank_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
        .clk       (CLK),
        .rst       (RST),
        .load      (1'b1),
        .load_word (resolved),
        .load_vld  (vld0_next),
        .word      (stage_word[k]),
        .vld       (stage_vld[k])
      );
    end else begin : g_rest
      dffrs_bank_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
        .clk       (CLK),
        .rst       (RST),
        .load      (EN),
        .load_word (stage_word[k-1]),
        .load_vld  (stage_vld[k-1]),
        .word      (stage_word[k]),
        .vld       (stage_vld[k])
      );
    end
  end

  assign Q     = stage_word[DEPTH-1];
  assign Q_VLD = stage_vld[DEPTH-1];

`ifdef DFFRS_BANK_OVR_CNT_EN
  logic [OVR_CNT_W-1:0] ovr_cnt;
  logic                 any_ovr;

  assign any_ovr = |(~RN | ~SETN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      ovr_cnt <= '0;
    end else if (any_ovr && (ovr_cnt != OVR_CNT_MAX)) begin
      ovr_cnt <= ovr_cnt + 8'd1;
    end
  end

  assign OVR_CNT = ovr_cnt;
`endif

endmodule

// File: tb/tb_dffrs_bank.sv
// tb/tb_dffrs_bank.sv - scoreboard bench for dffrs_bank (DEPTH=2 and DEPTH=1 instances)
module tb_dffrs_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] d;
  logic       d_vld;
  logic [3:0] rn;
  logic [3:0] setn;
  logic [3:0] q_a, q_b;
  logic       q_vld_a, q_vld_b;
  logic [7:0] ovr_cnt_a, ovr_cnt_b;

  typedef struct packed {
    logic [3:0] qa;
    logic       va;
    logic [3:0] qb;
    logic       vb;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference state: pipeline contents as plain arrays, updated from the block's rules.
  logic [3:0] m_a [2];
  logic       mv_a [2];
  logic [3:0] m_b;
  logic       mv_b;
  int         m_cnt;

  dffrs_bank #(.WIDTH(4), .DEPTH(2), .RESET_VAL(4'h6)) dut_a (
    .CLK(clk), .RST(rst), .EN(en), .D(d), .D_VLD(d_vld), .RN(rn), .SETN(setn),
    .Q(q_a), .Q_VLD(q_vld_a)
`ifdef DFFRS_BANK_OVR_CNT_EN
    , .OVR_CNT(ovr_cnt_a)
`endif
  );

  dffrs_bank #(.WIDTH(4), .DEPTH(1), .RESET_VAL(4'h9)) dut_b (
    .CLK(clk), .RST(rst), .EN(en), .D(d), .D_VLD(d_vld), .RN(rn), .SETN(setn),
    .Q(q_b), .Q_VLD(q_vld_b)
`ifdef DFFRS_BANK_OVR_CNT_EN
    , .OVR_CNT(ovr_cnt_b)
`endif
  );

`ifndef DFFRS_BANK_OVR_CNT_EN
  assign ovr_cnt_a = 8'h00;
  assign ovr_cnt_b = 8'h00;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] resolve_word(input logic [3:0] base, input logic [3:0] r, input logic [3:0] s);
    logic [3:0] w;
    for (int i = 0; i < 4; i++) begin
      if (r[i] == 1'b0)      w[i] = 1'b0;
      else if (s[i] == 1'b0) w[i] = 1'b1;
      else                   w[i] = base[i];
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] dd, input logic dv,
                      input logic [3:0] rnv, input logic [3:0] sv);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; d = dd; d_vld = dv; rn = rnv; setn = sv;
    if (r) begin
      m_a[0] = 4'h6; m_a[1] = 4'h6; mv_a[0] = 1'b0; mv_a[1] = 1'b0;
      m_b = 4'h9; mv_b = 1'b0;
      m_cnt = 0;
    end else begin
      if (e) begin
        m_a[1] = m_a[0]; mv_a[1] = mv_a[0];
        m_a[0] = resolve_word(dd, rnv, sv); mv_a[0] = dv;
        m_b = resolve_word(dd, rnv, sv); mv_b = dv;
      end else begin
        m_a[0] = resolve_word(m_a[0], rnv, sv);
        m_b = resolve_word(m_b, rnv, sv);
      end
      if (((rnv != 4'hF) || (sv != 4'hF)) && (m_cnt < 255)) m_cnt = m_cnt + 1;
    end
    x.qa = m_a[1]; x.va = mv_a[1]; x.qb = m_b; x.vb = mv_b; x.cnt = 8'(m_cnt);
    sb.push_back(x);
  endtask

  // Monitor: each entry describes the outputs right after the next rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("q_d2", {4'h0, q_a}, {4'h0, x.qa});
        chk("q_vld_d2", {7'h0, q_vld_a}, {7'h0, x.va});
        chk("q_d1", {4'h0, q_b}, {4'h0, x.qb});
        chk("q_vld_d1", {7'h0, q_vld_b}, {7'h0, x.vb});
`ifdef DFFRS_BANK_OVR_CNT_EN
        chk("ovr_cnt_d2", ovr_cnt_a, x.cnt);
        chk("ovr_cnt_d1", ovr_cnt_b, x.cnt);
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; d = 4'h0; d_vld = 1'b0; rn = 4'hF; setn = 4'hF;
    m_a[0] = 4'h0; m_a[1] = 4'h0; mv_a[0] = 1'b0; mv_a[1] = 1'b0;
    m_b = 4'h0; mv_b = 1'b0; m_cnt = 0;

    // reset and fill
    step(1, 0, 4'h0, 0, 4'hF, 4'hF);
    step(0, 1, 4'hA, 1, 4'hF, 4'hF);
    step(0, 1, 4'h5, 1, 4'hF, 4'hF);
    step(0, 1, 4'h0, 0, 4'hF, 4'hF);
    // override priority on incoming D
    step(0, 1, 4'h0, 1, 4'b0110, 4'b0011);
    step(0, 1, 4'h7, 1, 4'hF, 4'hF);
    step(0, 1, 4'h7, 0, 4'hF, 4'hF);
    // hold with in-place override
    step(0, 1, 4'hF, 1, 4'hF, 4'hF);
    step(0, 0, 4'h0, 0, 4'b1110, 4'hF);
    step(0, 0, 4'h3, 1, 4'hF, 4'hF);
    step(0, 1, 4'h2, 1, 4'hF, 4'hF);
    step(0, 1, 4'h2, 1, 4'hF, 4'hF);
    // mid-stream reset
    step(0, 1, 4'h3, 1, 4'hF, 4'hF);
    step(0, 1, 4'h4, 1, 4'hF, 4'hF);
    step(1, 1, 4'h8, 1, 4'h0, 4'h0);
    step(0, 1, 4'hC, 1, 4'hF, 4'hF);
    step(0, 1, 4'hD, 1, 4'hF, 4'hF);
    step(0, 1, 4'hE, 1, 4'hF, 4'hF);
    // EN toggling with set override while holding
    step(0, 1, 4'h9, 1, 4'hF, 4'hF);
    step(0, 0, 4'h0, 0, 4'hF, 4'b0110);
    step(0, 0, 4'h0, 0, 4'hF, 4'hF);

    for (int n = 0; n < 400; n++) begin
      logic r, e, dv;
      logic [3:0] dd, rnv, sv;
      r   = ($urandom_range(0, 31) == 0);
      e   = ($urandom_range(0, 3) != 0);
      dd  = 4'($urandom());
      dv  = 1'($urandom());
      rnv = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'hF;
      sv  = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'hF;
      step(r, e, dd, dv, rnv, sv);
    end

`ifdef DFFRS_BANK_OVR_CNT_EN
    step(1, 0, 4'h0, 0, 4'hF, 4'hF);
    for (int n = 0; n < 300; n++) begin
      step(0, 1'($urandom()), 4'($urandom()), 1'($urandom()), 4'b1110, 4'hF);
    end
    step(0, 1, 4'h1, 1, 4'hF, 4'hF);
    step(1, 0, 4'h0, 0, 4'b1110, 4'hF);
    step(0, 0, 4'h0, 0, 4'hF, 4'hF);
`endif

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 8'(sb.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
